divider_1_input: RTL
====================

# divider_1_input

Sequential restoring divider: 8-bit dividend by 4-bit divisor, all operands entered through one 4-bit data port using a load button and a start button. It is the inverse companion to the single-input shift-add multiplier on the same board. It produces an 8-bit quotient and 4-bit remainder, with seven-segment decode for quotient, remainder and divisor.

## Interface
- No parameters; widths fixed: dividend 8, divisor 4, quotient 8, remainder 4.
- i_clk  input  1  system clock, all state on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_load  input  1  load button, active-low, debounced and synchronous to i_clk
- i_start  input  1  start button, active-low, debounced and synchronous to i_clk
- i_data  input  4  operand nibble, sampled on a load press
- o_done  output  1  result valid, held high in FINISH
- o_err  output  1  divide-by-zero flag, held in FINISH
- o_Q  output  8  quotient
- o_R  output  4  remainder
- seg_o_Q_hundred, seg_o_Q_ten, seg_o_Q_unit  output  7 each  quotient digits
- seg_o_R_ten, seg_o_R_unit  output  7 each  remainder digits
- seg_i_D_ten, seg_i_D_unit  output  7 each  divisor digits

## Operation
- Press detection: load_prev/start_prev are registered copies of the buttons.
  - Load press = load_prev high and i_load low; one-cycle event per press. Start press is the same on i_start.
  - Holding a button low generates no further presses.
- States: IDLE, LOAD_DH, LOAD_DL, LOAD_DIV, CALC, FINISH.
- IDLE: on load press, dividend[7:4] <= i_data and go to LOAD_DH.
- LOAD_DH: on load press, dividend[3:0] <= i_data and go to LOAD_DL.
- LOAD_DL: on load press, divisor <= i_data and go to LOAD_DIV.
- LOAD_DIV:
  - Load press: dividend[7:4] <= i_data, go to LOAD_DH. This is the re-entry path to edit operands.
  - Start press with divisor != 0: clear the 5-bit partial remainder and 8-bit quotient, set counter = 0, go to CALC.
  - Start press with divisor == 0: o_err <= 1, o_done <= 1, o_Q <= 8'hFF, o_R <= 0, go to FINISH.
- Start presses in IDLE, LOAD_DH and LOAD_DL are ignored.
- CALC, one quotient bit per cycle, MSB first:
  - r = {rem[3:0], dividend[7-counter]}.
  - If r >= {1'b0, divisor}: rem <= r - divisor and quotient bit = 1. Otherwise rem <= r and quotient bit = 0.
  - Counter increments each cycle.
  - After the 8th iteration, o_Q and o_R are registered, o_done <= 1, and the state goes to FINISH.
  - All button presses are ignored in CALC.
- FINISH: outputs are held. A load press clears o_done, o_err, o_Q and o_R, captures dividend[7:4] <= i_data, and goes to LOAD_DH. Start presses are ignored.
- Simultaneous load and start press: load wins in every state.
- Seven-segment encoding is active-low, bit order gfedcba.
  - Digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - When o_err = 1, all quotient and remainder digits show dash 0111111.
  - Digit decode is combinational from o_Q, o_R and the divisor register.

## Timing
- Reset (async, i_rst high) sets:
  - State IDLE; counter, dividend, divisor, remainder and quotient all 0.
  - o_done = 0, o_err = 0, o_Q = 0, o_R = 0, load_prev = start_prev = 1.
  - All digits display "0".
- Reset mid-CALC aborts the operation immediately; no partial result is visible.
- Start press sampled at edge E0 moves the state to CALC. Iterations occur at E1..E8.
- o_done, o_Q and o_R become valid after E8, i.e. 8 cycles after the state enters CALC.
- Divide-by-zero: o_done and o_err are high one cycle after the start press.
- o_Q and o_R are stable and never change while o_done = 1.

## Test plan
- Load 0xC, 0x8, 0x7 (200 / 7), then start -> o_done rises 8 cycles after CALC entry; o_Q = 28, o_R = 4, o_err = 0; digits show 028 and 04.
- Load 0xF, 0xF, 0xF (255 / 15) -> o_Q = 17, o_R = 0. Load 0x0, 0x9, 0xC (9 / 12) -> o_Q = 0, o_R = 9.
- Load 0x5, 0xA, 0x0 (90 / 0), then start -> next cycle o_err = 1, o_done = 1, o_Q = 0xFF, o_R = 0, and quotient/remainder digits show dashes.
- Load 0x6, 0x4, 0x3, then load 0x1, 0x2, 0x5 (wrap re-entry), then start -> computes 18 / 5: o_Q = 3, o_R = 3. Start pressed in LOAD_DL is ignored, and a held load button captures only once.
- Assert i_rst at CALC iteration 4 -> all outputs 0 and state IDLE at once; a following full 100 / 9 sequence gives o_Q = 11, o_R = 1. Simultaneous load+start in LOAD_DIV -> load taken, state LOAD_DH.

Source files
------------

// File: rtl/divider_1_input_if.sv
// divider_1_input_if: button/data inputs and result/display outputs of the single-input divider
interface divider_1_input_if;
    logic       i_load;
    logic       i_start;
    logic [3:0] i_data;
    logic       o_done;
    logic       o_err;
    logic [7:0] o_Q;
    logic [3:0] o_R;
    logic [6:0] seg_o_Q_hundred;
    logic [6:0] seg_o_Q_ten;
    logic [6:0] seg_o_Q_unit;
    logic [6:0] seg_o_R_ten;
    logic [6:0] seg_o_R_unit;
    logic [6:0] seg_i_D_ten;
    logic [6:0] seg_i_D_unit;
    modport master (
        output i_load, i_start, i_data,
        input  o_done, o_err, o_Q, o_R,
        input  seg_o_Q_hundred, seg_o_Q_ten, seg_o_Q_unit,
        input  seg_o_R_ten, seg_o_R_unit, seg_i_D_ten, seg_i_D_unit
    );
    modport slave (
        input  i_load, i_start, i_data,
        output o_done, o_err, o_Q, o_R,
        output seg_o_Q_hundred, seg_o_Q_ten, seg_o_Q_unit,
        output seg_o_R_ten, seg_o_R_unit, seg_i_D_ten, seg_i_D_unit
    );
endinterface

// File: rtl/divider_1_input.sv
// divider_1_input: restoring 8/4 divider fed through one nibble port by load/start buttons,
// with active-low gfedcba seven-segment decode of quotient, remainder and divisor.
module divider_1_input (
    input logic i_clk,
    input logic i_rst,
    divider_1_input_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_DH, LOAD_DL, LOAD_DIV, CALC, FINISH} state_t;
    localparam logic [6:0] dash = 7'b0111111;
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] dvd_q, dvd_d, quo_q, quo_d, oq_q, oq_d;
    logic [3:0] dvs_q, dvs_d, rem_q, rem_d, or_q, or_d;
    logic done_q, done_d, err_q, err_d, load_prev_q, start_prev_q;
    logic load_press, start_press, ge;
    logic [4:0] r;
    assign load_press  = load_prev_q & ~bus.i_load;
    assign start_press = start_prev_q & ~bus.i_start;
    // partial remainder stays below the divisor, so four stored bits suffice
    assign r  = {rem_q, dvd_q[3'd7 - cnt_q]};
    assign ge = r >= {1'b0, dvs_q};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        done_d  = done_q;
        err_d   = err_q;
        oq_d    = oq_q;
        or_d    = or_q;
        case (state_q)
            IDLE: if (load_press) begin
                dvd_d[7:4] = bus.i_data;
                state_d    = LOAD_DH;
            end
            LOAD_DH: if (load_press) begin
                dvd_d[3:0] = bus.i_data;
                state_d    = LOAD_DL;
            end
            LOAD_DL: if (load_press) begin
                dvs_d   = bus.i_data;
                state_d = LOAD_DIV;
            end
            LOAD_DIV: if (load_press) begin
                dvd_d[7:4] = bus.i_data;
                state_d    = LOAD_DH;
            end else if (start_press && dvs_q != 4'd0) begin
                rem_d   = 4'd0;
                quo_d   = 8'd0;
                cnt_d   = 3'd0;
                state_d = CALC;
            end else if (start_press) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                oq_d    = 8'hFF;
                or_d    = 4'd0;
                state_d = FINISH;
            end
            CALC: begin
                rem_d = ge ? 4'(r - {1'b0, dvs_q}) : r[3:0];
                quo_d = {quo_q[6:0], ge};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    oq_d    = quo_d;
                    or_d    = rem_d;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: if (load_press) begin
                done_d     = 1'b0;
                err_d      = 1'b0;
                oq_d       = 8'd0;
                or_d       = 4'd0;
                dvd_d[7:4] = bus.i_data;
                state_d    = LOAD_DH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            dvd_q        <= 8'd0;
            dvs_q        <= 4'd0;
            rem_q        <= 4'd0;
            quo_q        <= 8'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            oq_q         <= 8'd0;
            or_q         <= 4'd0;
            load_prev_q  <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            done_q       <= done_d;
            err_q        <= err_d;
            oq_q         <= oq_d;
            or_q         <= or_d;
            load_prev_q  <= bus.i_load;
            start_prev_q <= bus.i_start;
        end
    end
    function automatic logic [6:0] seg7(input logic [7:0] v);
        case (v)
            8'd0: return 7'b1000000;
            8'd1: return 7'b1111001;
            8'd2: return 7'b0100100;
            8'd3: return 7'b0110000;
            8'd4: return 7'b0011001;
            8'd5: return 7'b0010010;
            8'd6: return 7'b0000010;
            8'd7: return 7'b1111000;
            8'd8: return 7'b0000000;
            8'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction
    assign bus.o_done          = done_q;
    assign bus.o_err           = err_q;
    assign bus.o_Q             = oq_q;
    assign bus.o_R             = or_q;
    assign bus.seg_o_Q_hundred = err_q ? dash : seg7(oq_q / 8'd100);
    assign bus.seg_o_Q_ten     = err_q ? dash : seg7((oq_q / 8'd10) % 8'd10);
    assign bus.seg_o_Q_unit    = err_q ? dash : seg7(oq_q % 8'd10);
    assign bus.seg_o_R_ten     = err_q ? dash : seg7(8'(or_q / 4'd10));
    assign bus.seg_o_R_unit    = err_q ? dash : seg7(8'(or_q % 4'd10));
    assign bus.seg_i_D_ten     = seg7(8'(dvs_q / 4'd10));
    assign bus.seg_i_D_unit    = seg7(8'(dvs_q % 4'd10));
endmodule
